// File: rtl/d_div2.sv
// ============================================================================
// Module   : d_div2
// Brief    : 32/16 unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module d_div2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [16:0] r_prem;
    logic [15:0] r_low;
    logic [15:0] r_div;
    logic [15:0] r_quot;
    logic [15:0] r_rem;
    logic        r_err;

    logic        w_err_in;
    logic        w_last;
    logic [16:0] w_shift;
    logic [16:0] w_diff;
    logic        w_qbit;
    logic [16:0] w_prem_nx;

    // Quotient fits in 16 bits only when the upper dividend half is below the divisor.
    assign w_err_in  = (divisor == 16'd0) || (dividend[31:16] >= divisor);
    assign w_last    = (r_cnt == 4'd15);

    // r_prem[16] stands for the bit shifted out of w_shift; if set, the trial always succeeds.
    assign w_shift   = {r_prem[15:0], r_low[15]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_qbit    = r_prem[16] | (w_shift >= {1'b0, r_div});
    assign w_prem_nx = w_qbit ? w_diff : w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_err_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 4'd0;
            r_prem <= 17'd0;
            r_low  <= 16'd0;
            r_div  <= 16'd0;
            r_quot <= 16'd0;
            r_rem  <= 16'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_div  <= divisor;
                        r_cnt  <= 4'd0;
                        r_prem <= {1'b0, dividend[31:16]};
                        r_low  <= dividend[15:0];
                        if (w_err_in) begin
                            r_quot <= 16'hFFFF;
                            r_rem  <= dividend[15:0];
                            r_err  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    // r_low doubles as the quotient shift register as dividend bits drain out.
                    r_prem <= w_prem_nx;
                    r_low  <= {r_low[14:0], w_qbit};
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_quot <= {r_low[14:0], w_qbit};
                        r_rem  <= w_prem_nx[15:0];
                        r_err  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign err       = r_err;
    assign busy      = (r_state == CALC);
    assign done      = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_d_div2.sv
// ============================================================================
// Module   : tb_d_div2
// Brief    : Directed self-checking bench for d_div2 with a cycle-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_d_div2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    d_div2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: {err, quotient, remainder}
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [15:0] b);
        logic [31:0] q;
        if (b == 16'd0) return {1'b1, 16'hFFFF, a[15:0]};
        q = a / {16'd0, b};
        if (q > 32'd65535) return {1'b1, 16'hFFFF, a[15:0]};
        return {1'b0, q[15:0], 16'(a % {16'd0, b})};
    endfunction

    // Timing model: 16 busy cycles then a done cycle, or a done cycle straight away on error.
    int          m_calc;
    logic        m_done;
    logic [15:0] m_q, m_r, p_q, p_r;
    logic        m_e, p_e;
    logic [32:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_calc <= 0;
            m_done <= 1'b0;
            m_q <= '0; m_r <= '0; m_e <= 1'b0;
            p_q <= '0; p_r <= '0; p_e <= 1'b0;
        end else begin
            if (m_done) m_done <= 1'b0;
            if (m_calc > 0) begin
                m_calc <= m_calc - 1;
                if (m_calc == 1) begin
                    m_done <= 1'b1;
                    m_q <= p_q; m_r <= p_r; m_e <= p_e;
                end
            end else if (!m_done && start) begin
                m_res = ref_div(dividend, divisor);
                if (m_res[32]) begin
                    m_done <= 1'b1;
                    m_q <= m_res[31:16]; m_r <= m_res[15:0]; m_e <= 1'b1;
                end else begin
                    m_calc <= 16;
                    p_q <= m_res[31:16]; p_r <= m_res[15:0]; p_e <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_busy",      {31'd0, busy}, {31'd0, m_calc > 0});
            chk("model_done",      {31'd0, done}, {31'd0, m_done});
            chk("model_quotient",  {16'd0, quotient},  {16'd0, m_q});
            chk("model_remainder", {16'd0, remainder}, {16'd0, m_r});
            chk("model_err",       {31'd0, err},  {31'd0, m_e});
        end
    end

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Latency counts negedges after the capture edge: 1 for error, 17 otherwise.
    task automatic run(input logic [31:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ee, input int elat, input string name);
        int n;
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
        wait_done(1, n);
        chk({name, "_done"},      {31'd0, done}, 32'd1);
        chk({name, "_latency"},   n, elat);
        chk({name, "_quotient"},  {16'd0, quotient},  {16'd0, eq});
        chk({name, "_remainder"}, {16'd0, remainder}, {16'd0, er});
        chk({name, "_err"},       {31'd0, err}, {31'd0, ee});
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {quotient, remainder}, 32'd0);
        chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17, "basic");
        run(32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 17, "full_range");
        run(32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1,  "div_zero");
        run(32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1,  "overflow");
        run(32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, "max_quot");
        run(32'h0000_0007, 16'h0007, 16'h0001, 16'h0000, 1'b0, 17, "equal");
        run(32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 17, "zero_dvd");
        run(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1,  "ovf_edge");
        run(32'h0012_3456, 16'h1234, 16'h0100, 16'h0056, 1'b0, 17, "mid");

        // Start re-pulsed mid-calculation with other operands must be ignored.
        start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 5) begin
                start = 1'b1; dividend = 32'd50; divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ignore_latency",  n, 17);
        chk("ignore_quotient", {16'd0, quotient},  32'h0000_014D);
        chk("ignore_remainder", {16'd0, remainder}, 32'h0000_0001);
        @(negedge clk);

        // Asynchronous reset partway through a calculation.
        start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {quotient, remainder}, 32'd0);
        chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_still_idle", {30'd0, busy, done}, 32'd0);
        run(32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17, "after_reset");

        // Start held high: the next operation is captured on the first idle cycle.
        start = 1'b1; dividend = 32'h0000_0064; divisor = 16'h0007;
        wait_done(0, n);
        chk("b2b_first_latency", n, 17);
        chk("b2b_first_quotient", {16'd0, quotient}, 32'h0000_000E);
        dividend = 32'h0012_3456; divisor = 16'h1234;
        @(negedge clk);
        wait_done(1, n);
        chk("b2b_period", n, 18);
        chk("b2b_second_quotient",  {16'd0, quotient},  32'h0000_0100);
        chk("b2b_second_remainder", {16'd0, remainder}, 32'h0000_0056);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
